// File: rtl/fp_mult_seq_pkg.sv
// Shared types and status codes for the sequential floating-point multiplier.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_CALC,
    S_NORM,
    S_ROUND,
    S_DONE
  } fpm_state_t;

  typedef enum logic [1:0] {
    FPC_ZERO,
    FPC_NORMAL,
    FPC_INF,
    FPC_NAN
  } fp_class_t;

  localparam logic [1:0] ESP_OK  = 2'b00;
  localparam logic [1:0] ESP_NAN = 2'b01;
  localparam logic [1:0] ESP_OVF = 2'b10;
  localparam logic [1:0] ESP_UNF = 2'b11;

endpackage

// File: rtl/fp_mult_seq_if.sv
// Operand/result handshake bundle between the ALU (master) and fp_mult_seq (slave).
interface fp_mult_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Resultado;
  logic [1:0]   esp;

  modport master (
    output in_valid, dataA, dataB, out_ready,
    input  in_ready, out_valid, Resultado, esp
  );

  modport slave (
    input  in_valid, dataA, dataB, out_ready,
    output in_ready, out_valid, Resultado, esp
  );
endinterface

// File: rtl/fp_mult_seq_mant_mult.sv
// Iterative radix-2 shift-add unsigned multiplier: N iterations per operation,
// the first one performed on the start edge so done rises N edges after start.
module seq_mant_mult #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CNT_W = $clog2(N + 1);

  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     mplr_q, mplr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic [N-1:0] src_acc, src_mplr, src_mcand;
  logic [N:0]   sum;
  logic         step;

  // {acc, mplr} is the partial product; each step adds the multiplicand and shifts right.
  always_comb begin
    step      = start || (cnt_q != '0);
    src_acc   = start ? '0 : acc_q;
    src_mplr  = start ? b  : mplr_q;
    src_mcand = start ? a  : mcand_q;
    sum       = {1'b0, src_acc} + (src_mplr[0] ? {1'b0, src_mcand} : '0);

    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (step) begin
      mcand_d = src_mcand;
      acc_d   = sum[N:1];
      mplr_d  = {sum[0], src_mplr[N-1:1]};
      cnt_d   = start ? CNT_W'(N - 1) : cnt_q - CNT_W'(1);
      done_d  = start ? (N == 1) : (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign done    = done_q;
  assign product = {acc_q, mplr_q};

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754-style multiplier: classify, iterative significand product,
// normalise, round-to-nearest-even, with valid/ready on both sides.
module fp_mult_seq
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          rst_n,
  fp_mult_seq_if.slave bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int N   = MAN_W + 1;
  localparam int E_W = EXP_W + 2;

  localparam logic signed [E_W-1:0] BIAS     = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] EXP_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] EXP_ZERO = '0;
  localparam logic signed [E_W-1:0] EXP_ONE  = E_W'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic fp_class_t classify(input logic [W-1:0] v);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = v[W-2 -: EXP_W];
    f = v[MAN_W-1:0];
    if (e == '0) return FPC_ZERO;
    if (&e)      return (f == '0) ? FPC_INF : FPC_NAN;
    return FPC_NORMAL;
  endfunction

  // Returns {fraction, guard, sticky}; product lies in [1,4) with two integer bits.
  function automatic logic [MAN_W+1:0] normalise(input logic [2*N-1:0] p);
    logic [MAN_W-1:0] f;
    logic             g;
    logic             s;
    if (p[2*N-1]) begin
      f = p[2*N-2 -: MAN_W];
      g = p[MAN_W];
      s = |p[MAN_W-1:0];
    end else begin
      f = p[2*N-3 -: MAN_W];
      g = p[MAN_W-1];
      s = |p[MAN_W-2:0];
    end
    return {f, g, s};
  endfunction

  // Round to nearest even, then saturate to inf or flush to zero; returns {word, esp}.
  function automatic logic [W+1:0] round_pack(input logic s, input logic signed [E_W-1:0] e_in,
                                               input logic [MAN_W-1:0] f, input logic g,
                                               input logic st);
    logic [MAN_W:0]           sum;
    logic signed [E_W-1:0]    e;
    sum = {1'b0, f} + {{MAN_W{1'b0}}, g & (st | f[0])};
    e   = e_in + (sum[MAN_W] ? EXP_ONE : EXP_ZERO);
    if (e >= EXP_MAX) return {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}, ESP_OVF};
    if (e <= EXP_ZERO) return {s, {(W-1){1'b0}}, ESP_UNF};
    return {s, e[EXP_W-1:0], sum[MAN_W-1:0], ESP_OK};
  endfunction

  fpm_state_t            state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic                  sign_q, sign_d;
  logic signed [E_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0]      frac_q, frac_d;
  logic                  guard_q, guard_d;
  logic                  sticky_q, sticky_d;
  logic                  special_q, special_d;
  logic [W-1:0]          res_q, res_d;
  logic [1:0]            esp_q, esp_d;

  fp_class_t             cls_a, cls_b;
  logic                  any_nan, any_inf, any_zero, is_special;
  logic signed [E_W-1:0] exp_sum;
  logic                  mul_start, mul_done;
  logic [2*N-1:0]        mul_prod;

  always_comb begin
    cls_a      = classify(a_q);
    cls_b      = classify(b_q);
    any_nan    = (cls_a == FPC_NAN) || (cls_b == FPC_NAN) ||
                 (cls_a == FPC_ZERO && cls_b == FPC_INF) ||
                 (cls_a == FPC_INF && cls_b == FPC_ZERO);
    any_inf    = (cls_a == FPC_INF) || (cls_b == FPC_INF);
    any_zero   = (cls_a == FPC_ZERO) || (cls_b == FPC_ZERO);
    is_special = any_nan || any_inf || any_zero;
    exp_sum    = $signed({2'b00, a_q[W-2 -: EXP_W]}) +
                 $signed({2'b00, b_q[W-2 -: EXP_W]}) - BIAS;
    mul_start  = (state_q == S_CLASS) && !is_special;
  end

  seq_mant_mult #(.N(N)) u_mant_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       ({1'b1, a_q[MAN_W-1:0]}),
    .b       ({1'b1, b_q[MAN_W-1:0]}),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Specials pass through ROUND untouched so both paths share one result register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_CLASS;
      S_CLASS: state_d = is_special ? S_ROUND : S_CALC;
      S_CALC:  if (mul_done) state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    special_d = special_q;
    res_d     = res_q;
    esp_d     = esp_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d = bus.dataA;
          b_d = bus.dataB;
        end
      end
      S_CLASS: begin
        sign_d    = a_q[W-1] ^ b_q[W-1];
        exp_d     = exp_sum;
        special_d = is_special;
        if (any_nan) begin
          res_d = QNAN;
          esp_d = ESP_NAN;
        end else if (any_inf) begin
          res_d = {a_q[W-1] ^ b_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          esp_d = ESP_OK;
        end else if (any_zero) begin
          res_d = {a_q[W-1] ^ b_q[W-1], {(W-1){1'b0}}};
          esp_d = ESP_OK;
        end
      end
      S_NORM: begin
        {frac_d, guard_d, sticky_d} = normalise(mul_prod);
        if (mul_prod[2*N-1]) exp_d = exp_q + EXP_ONE;
      end
      S_ROUND: begin
        if (!special_q) {res_d, esp_d} = round_pack(sign_q, exp_q, frac_q, guard_q, sticky_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      frac_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      special_q <= 1'b0;
      res_q     <= '0;
      esp_q     <= ESP_OK;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      frac_q    <= frac_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      special_q <= special_d;
      res_q     <= res_d;
      esp_q     <= esp_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.Resultado = res_q;
  assign bus.esp       = esp_q;

endmodule
